// File: rtl/demux_4_x_stream.sv
// demux_4_x_stream
//   Registered 1-to-4 stream demultiplexer. A single valid/ready input stream
//   carries a 2-bit channel select with every word. Each word is written into
//   a per-channel FIFO of DEPTH entries. Each FIFO drains on its own
//   valid/ready output, so the four consumers can stall independently.
//
// Ports
//   clk        single clock, rising edge
//   rst        synchronous, active-high reset
//   in_data    input word
//   in_sel     destination channel (0..3) for in_data
//   in_valid   in_data/in_sel valid
//   in_ready   the channel addressed by in_sel has room (never during reset)
//   out_data   channel k word at [k*BUS_WIDTH +: BUS_WIDTH], 0 when empty
//   out_valid  bit k: channel k holds a word
//   out_ready  bit k: channel k consumer accepts
//   out_count  channel k occupancy at [k*CNT_W +: CNT_W]

module demux_4_x_stream #(
  parameter int BUS_WIDTH = 8,
  parameter int DEPTH     = 2
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [BUS_WIDTH-1:0]               in_data,
  input  logic [1:0]                         in_sel,
  input  logic                               in_valid,
  output logic                               in_ready,
  output logic [4*BUS_WIDTH-1:0]             out_data,
  output logic [3:0]                         out_valid,
  input  logic [3:0]                         out_ready,
  output logic [4*($clog2(DEPTH)+1)-1:0]     out_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [3:0] not_full;

  // Ready depends only on the registered counts and in_sel, so there is no
  // combinational path from out_ready or in_valid to in_ready.
  assign in_ready = !rst && not_full[in_sel];

  for (genvar k = 0; k < 4; k++) begin : g_chan
    logic [BUS_WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic                 push, pop;

    assign push = in_valid && in_ready && (in_sel == 2'(k));
    assign pop  = out_valid[k] && out_ready[k];

    always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      // Pointers are exactly PTR_W bits, so they wrap from DEPTH-1 to 0.
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        wr_ptr_q <= wr_ptr_d;
        rd_ptr_q <= rd_ptr_d;
        count_q  <= count_d;
      end
    end

    // Storage needs no reset: the count gates everything that is visible.
    // push already excludes reset through in_ready.
    always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= in_data;
    end

    assign not_full[k]                         = (count_q != FULL_CNT);
    assign out_valid[k]                        = (count_q != '0);
    assign out_count[k*CNT_W +: CNT_W]         = count_q;
    assign out_data[k*BUS_WIDTH +: BUS_WIDTH]  = out_valid[k] ? mem_q[rd_ptr_q] : '0;
  end

endmodule

// File: tb/tb_demux_4_x_stream.sv
module tb_demux_4_x_stream;

  logic        clk;
  logic        rst;
  logic [7:0]  in_data;
  logic [1:0]  in_sel;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out_data;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic [7:0]  out_count;

  int checks = 0;
  int errors = 0;

  demux_4_x_stream #(.BUS_WIDTH(8), .DEPTH(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_count (out_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got t=%0t, required finish earlier", $time);
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        rst;
    logic        valid;
    logic [1:0]  sel;
    logic [7:0]  data;
    logic [3:0]  ordy;
    logic [3:0]  e_vld;
    logic [31:0] e_data;
    logic [7:0]  e_cnt;
    logic        e_rdy;
  } vec_t;

  vec_t vecs [14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] s, input logic [7:0] d, input logic [3:0] r);
    in_valid  = v;
    in_sel    = s;
    in_data   = d;
    out_ready = r;
  endtask

  initial begin
    // Each row: inputs held across one edge, expectations sampled 1 time
    // unit after that edge with the same inputs still applied.
    //          rst   vld   sel    data   ordy     e_vld    e_data        e_cnt  e_rdy
    vecs[0]  = '{1'b1, 1'b0, 2'd0, 8'h00, 4'b0000, 4'b0000, 32'h0000_0000, 8'h00, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 2'd0, 8'h00, 4'b0000, 4'b0000, 32'h0000_0000, 8'h00, 1'b1};
    vecs[2]  = '{1'b0, 1'b1, 2'd2, 8'h11, 4'b1111, 4'b0100, 32'h0011_0000, 8'h10, 1'b1};
    vecs[3]  = '{1'b0, 1'b0, 2'd2, 8'h11, 4'b1111, 4'b0000, 32'h0000_0000, 8'h00, 1'b1};
    vecs[4]  = '{1'b0, 1'b1, 2'd1, 8'hA0, 4'b0000, 4'b0010, 32'h0000_A000, 8'h04, 1'b1};
    vecs[5]  = '{1'b0, 1'b1, 2'd1, 8'hA1, 4'b0000, 4'b0010, 32'h0000_A000, 8'h08, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 2'd0, 8'h00, 4'b0000, 4'b0010, 32'h0000_A000, 8'h08, 1'b1};
    vecs[7]  = '{1'b0, 1'b1, 2'd0, 8'hB0, 4'b0000, 4'b0011, 32'h0000_A0B0, 8'h09, 1'b1};
    vecs[8]  = '{1'b0, 1'b0, 2'd1, 8'h00, 4'b0010, 4'b0011, 32'h0000_A1B0, 8'h05, 1'b1};
    vecs[9]  = '{1'b0, 1'b0, 2'd1, 8'h00, 4'b0010, 4'b0001, 32'h0000_00B0, 8'h01, 1'b1};
    vecs[10] = '{1'b0, 1'b0, 2'd0, 8'h00, 4'b0001, 4'b0000, 32'h0000_0000, 8'h00, 1'b1};
    vecs[11] = '{1'b0, 1'b1, 2'd3, 8'hC0, 4'b0000, 4'b1000, 32'hC000_0000, 8'h40, 1'b1};
    vecs[12] = '{1'b0, 1'b1, 2'd3, 8'hC1, 4'b1000, 4'b1000, 32'hC100_0000, 8'h40, 1'b1};
    vecs[13] = '{1'b0, 1'b0, 2'd3, 8'h00, 4'b1000, 4'b0000, 32'h0000_0000, 8'h00, 1'b1};

    rst = 1'b1;
    drive(1'b0, 2'd0, 8'h00, 4'b0000);

    for (int i = 0; i < 14; i++) begin
      rst = vecs[i].rst;
      drive(vecs[i].valid, vecs[i].sel, vecs[i].data, vecs[i].ordy);
      step();
      check($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'(vecs[i].e_vld));
      check($sformatf("vec%0d out_data", i),  out_data,        vecs[i].e_data);
      check($sformatf("vec%0d out_count", i), 32'(out_count), 32'(vecs[i].e_cnt));
      check($sformatf("vec%0d in_ready", i),  32'(in_ready),  32'(vecs[i].e_rdy));
    end

    // Channel 3 full, word held on sel=3, out_ready[3] pulsed once.
    drive(1'b1, 2'd3, 8'hD0, 4'b0000);
    step();
    check("ch3 fill1 count", 32'(out_count[7:6]), 32'd1);
    drive(1'b1, 2'd3, 8'hD1, 4'b0000);
    step();
    check("ch3 full count", 32'(out_count[7:6]), 32'd2);
    check("ch3 full in_ready", 32'(in_ready), 32'd0);
    drive(1'b1, 2'd3, 8'hD2, 4'b1000);
    #1;
    check("ch3 held in_ready", 32'(in_ready), 32'd0);
    step();
    out_ready = 4'b0000;
    #1;
    check("ch3 one pop count", 32'(out_count[7:6]), 32'd1);
    check("ch3 one pop data", 32'(out_data[31:24]), 32'hD1);
    check("ch3 ready rises", 32'(in_ready), 32'd1);
    step();
    check("ch3 refill count", 32'(out_count[7:6]), 32'd2);
    check("ch3 refill data", 32'(out_data[31:24]), 32'hD1);
    check("ch3 refill in_ready", 32'(in_ready), 32'd0);
    drive(1'b0, 2'd3, 8'h00, 4'b1000);
    step();
    check("ch3 drain1 data", 32'(out_data[31:24]), 32'hD2);
    check("ch3 drain1 count", 32'(out_count[7:6]), 32'd1);
    step();
    check("ch3 drain2 valid", 32'(out_valid), 32'd0);

    // Stream 8 words into channel 0 with its consumer always ready.
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 2'd0, 8'(8'h30 + i), 4'b0001);
      #1;
      check($sformatf("stream%0d in_ready", i), 32'(in_ready), 32'd1);
      step();
      check($sformatf("stream%0d data", i),  32'(out_data[7:0]), 32'(8'h30 + i));
      check($sformatf("stream%0d count", i), 32'(out_count[1:0]), 32'd1);
    end
    drive(1'b0, 2'd0, 8'h00, 4'b0001);
    step();
    check("stream end valid", 32'(out_valid), 32'd0);

    // Mid-stream reset discards everything buffered.
    drive(1'b1, 2'd0, 8'hE0, 4'b0000);
    step();
    drive(1'b1, 2'd0, 8'hE1, 4'b0000);
    step();
    drive(1'b1, 2'd2, 8'hF0, 4'b0000);
    step();
    check("pre-rst valid", 32'(out_valid), 32'b0101);
    check("pre-rst count", 32'(out_count), 32'h12);
    rst = 1'b1;
    drive(1'b1, 2'd1, 8'hEE, 4'b0000);
    #1;
    check("rst in_ready", 32'(in_ready), 32'd0);
    step();
    rst = 1'b0;
    drive(1'b0, 2'd0, 8'h00, 4'b0000);
    #1;
    check("post-rst valid", 32'(out_valid), 32'd0);
    check("post-rst count", 32'(out_count), 32'd0);
    check("post-rst data", out_data, 32'd0);
    for (int s = 0; s < 4; s++) begin
      in_sel = 2'(s);
      #1;
      check($sformatf("post-rst in_ready sel%0d", s), 32'(in_ready), 32'd1);
    end
    drive(1'b1, 2'd0, 8'h5A, 4'b0000);
    step();
    check("post-rst push valid", 32'(out_valid), 32'b0001);
    check("post-rst push data", out_data, 32'h0000_005A);
    check("post-rst push count", 32'(out_count), 32'h01);
    drive(1'b0, 2'd0, 8'h00, 4'b0001);
    step();
    check("post-rst only word", 32'(out_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
